exe_unit_pipelined: RTL

Parametrised execute stage for the RV32I pipeline, between decode and memory. It accepts one decoded instruction per valid/ready handshake and computes the result with an internal ALU, optionally using a serial (1-bit-per-cycle) shifter. It raises a one-cycle register-forward pulse and a branch-redirect pulse. Load/store results are queued in an OUT_DEPTH-entry output FIFO so a stalled memory stage does not immediately back-pressure decode.

---
 rtl/exe_unit_pipelined.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/exe_unit_pipelined.sv
// rtl/exe_unit_pipelined.sv - RV32I execute stage with optional serial shifter and memory-side FIFO
module exe_unit_pipelined #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OUT_DEPTH      = 2,
  parameter int SERIAL_SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [XLEN-1:0]           i_in_pc,
  input  logic [6:0]                i_in_opcode,
  input  logic [2:0]                i_in_funct3,
  input  logic                      i_in_funct7b5,
  input  logic [XLEN-1:0]           i_in_rs1,
  input  logic [XLEN-1:0]           i_in_rs2,
  input  logic [XLEN-1:0]           i_in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] i_in_rd,
  output logic                      o_mem_valid,
  input  logic                      i_mem_ready,
  output logic [6:0]                o_mem_opcode,
  output logic [2:0]                o_mem_funct3,
  output logic [XLEN-1:0]           o_mem_addr,
  output logic [XLEN-1:0]           o_mem_rs2,
  output logic [REG_ADDR_WIDTH-1:0] o_mem_rd,
  output logic                      o_fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] o_fwd_rd,
  output logic [XLEN-1:0]           o_fwd_data,
  output logic                      o_redir_valid,
  output logic [XLEN-1:0]           o_redir_pc
);
  localparam int SHW = $clog2(XLEN);
  localparam int PW  = $clog2(OUT_DEPTH);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  state_t r_state, w_state_nxt;

  logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm, r_work;
  logic [6:0] r_opcode;
  logic [2:0] r_funct3;
  logic r_f7b5;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [SHW-1:0] r_cnt;

  logic [6:0] r_fifo_op [OUT_DEPTH];
  logic [2:0] r_fifo_f3 [OUT_DEPTH];
  logic [XLEN-1:0] r_fifo_addr [OUT_DEPTH];
  logic [XLEN-1:0] r_fifo_rs2 [OUT_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] r_fifo_rd [OUT_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0] r_count;

  logic w_is_r, w_is_i, w_is_mem, w_writes, w_full, w_push, w_pop;
  logic w_done, w_complete, w_accept, w_in_shift, w_taken;
  logic [XLEN-1:0] w_op_b, w_alu, w_result, w_pc_imm, w_rs1_imm;
  logic [SHW-1:0] w_shamt, w_in_shamt;

  assign w_is_r    = (r_opcode == OP_R);
  assign w_is_i    = (r_opcode == OP_I);
  assign w_is_mem  = (r_opcode == OP_LOAD) || (r_opcode == OP_STORE);
  assign w_writes  = w_is_r || w_is_i || (r_opcode == OP_LUI) || (r_opcode == OP_AUIPC) ||
                     (r_opcode == OP_JAL) || (r_opcode == OP_JALR);
  assign w_full    = (r_count == (PW+1)'(OUT_DEPTH));
  assign w_done    = (r_cnt == '0);
  // A same-cycle pop does not make room; only the registered count matters.
  assign w_complete = (r_state == S_EXEC) && !i_stall && !i_flush && w_done && (!w_is_mem || !w_full);
  assign o_in_ready = !i_stall && !i_flush && ((r_state == S_IDLE) || w_complete);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_push     = w_complete && w_is_mem;
  assign w_pop      = o_mem_valid && i_mem_ready;

  assign w_in_shift = ((i_in_opcode == OP_R) || (i_in_opcode == OP_I)) &&
                      ((i_in_funct3 == 3'b001) || (i_in_funct3 == 3'b101));
  assign w_in_shamt = (i_in_opcode == OP_R) ? i_in_rs2[SHW-1:0] : i_in_imm[SHW-1:0];

  assign w_op_b    = w_is_r ? r_rs2 : r_imm;
  assign w_shamt   = w_op_b[SHW-1:0];
  assign w_pc_imm  = r_pc + r_imm;
  assign w_rs1_imm = r_rs1 + r_imm;

  always_comb begin
    w_alu = '0;
    case (r_funct3)
      3'b000: w_alu = (w_is_r && r_f7b5) ? r_rs1 - w_op_b : r_rs1 + w_op_b;
      3'b001: w_alu = (SERIAL_SHIFT != 0) ? r_work : (r_rs1 << w_shamt);
      3'b010: w_alu = {{(XLEN-1){1'b0}}, $signed(r_rs1) < $signed(w_op_b)};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, r_rs1 < w_op_b};
      3'b100: w_alu = r_rs1 ^ w_op_b;
      3'b101: w_alu = (SERIAL_SHIFT != 0) ? r_work :
                      r_f7b5 ? $unsigned($signed(r_rs1) >>> w_shamt) : (r_rs1 >> w_shamt);
      3'b110: w_alu = r_rs1 | w_op_b;
      default: w_alu = r_rs1 & w_op_b;
    endcase
  end

  always_comb begin
    w_result = w_alu;
    case (r_opcode)
      OP_LUI:           w_result = r_imm;
      OP_AUIPC:         w_result = w_pc_imm;
      OP_JAL, OP_JALR:  w_result = r_pc + XLEN'(4);
      default:          w_result = w_alu;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_funct3)
      3'b000: w_taken = (r_rs1 == r_rs2);
      3'b001: w_taken = (r_rs1 != r_rs2);
      3'b100: w_taken = ($signed(r_rs1) < $signed(r_rs2));
      3'b101: w_taken = ($signed(r_rs1) >= $signed(r_rs2));
      3'b110: w_taken = (r_rs1 < r_rs2);
      3'b111: w_taken = (r_rs1 >= r_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush)         w_state_nxt = S_IDLE;
    else if (w_accept)   w_state_nxt = S_EXEC;
    else if (w_complete) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0; r_work <= '0;
      r_opcode <= '0; r_funct3 <= '0; r_f7b5 <= 1'b0; r_rd <= '0; r_cnt <= '0;
    end else if (w_accept) begin
      r_pc <= i_in_pc; r_rs1 <= i_in_rs1; r_rs2 <= i_in_rs2; r_imm <= i_in_imm;
      r_opcode <= i_in_opcode; r_funct3 <= i_in_funct3; r_f7b5 <= i_in_funct7b5; r_rd <= i_in_rd;
      r_work <= i_in_rs1;
      r_cnt  <= ((SERIAL_SHIFT != 0) && w_in_shift) ? w_in_shamt : '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if ((r_state == S_EXEC) && !i_stall && !w_done) begin
      r_cnt  <= r_cnt - SHW'(1);
      r_work <= (r_funct3 == 3'b001) ? {r_work[XLEN-2:0], 1'b0}
                                     : {r_f7b5 & r_work[XLEN-1], r_work[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fwd_valid <= 1'b0; o_fwd_rd <= '0; o_fwd_data <= '0;
      o_redir_valid <= 1'b0; o_redir_pc <= '0;
    end else begin
      o_fwd_valid   <= w_complete && w_writes && (r_rd != '0);
      o_redir_valid <= w_complete && (((r_opcode == OP_BRANCH) && w_taken) ||
                                      (r_opcode == OP_JAL) || (r_opcode == OP_JALR));
      if (w_complete) begin
        o_fwd_rd   <= r_rd;
        o_fwd_data <= w_result;
        o_redir_pc <= (r_opcode == OP_JALR) ? {w_rs1_imm[XLEN-1:1], 1'b0} : w_pc_imm;
      end
    end
  end

  // Entries are reset so the head reads as zero before anything is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_fifo_op[i] <= '0; r_fifo_f3[i] <= '0; r_fifo_addr[i] <= '0;
        r_fifo_rs2[i] <= '0; r_fifo_rd[i] <= '0;
      end
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_op[r_wptr] <= r_opcode; r_fifo_f3[r_wptr] <= r_funct3;
        r_fifo_addr[r_wptr] <= w_rs1_imm; r_fifo_rs2[r_wptr] <= r_rs2; r_fifo_rd[r_wptr] <= r_rd;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
    end
  end

  assign o_mem_valid  = (r_count != '0);
  assign o_mem_opcode = r_fifo_op[r_rptr];
  assign o_mem_funct3 = r_fifo_f3[r_rptr];
  assign o_mem_addr   = r_fifo_addr[r_rptr];
  assign o_mem_rs2    = r_fifo_rs2[r_rptr];
  assign o_mem_rd     = r_fifo_rd[r_rptr];
endmodule
